// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: state encoding, digit limits and the disp_bcd field layout
// (the field offsets are also consumed by the VGA digit renderer).
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   localparam logic [3:0] DIG_MAX_9 = 4'd9;
   localparam logic [3:0] DIG_MAX_5 = 4'd5;

   localparam int DIG_W     = 4;
   localparam int BCD_W     = 6 * DIG_W;
   localparam int OFF_CS_U  = 0;
   localparam int OFF_CS_T  = 4;
   localparam int OFF_SEC_U = 8;
   localparam int OFF_SEC_T = 12;
   localparam int OFF_MIN_U = 16;
   localparam int OFF_MIN_T = 20;

   // Value a bcd_digit will hold after the coming edge, so the display register
   // can follow the live count on the tick edge itself.
   function automatic logic [DIG_W-1:0] digit_next(input logic [DIG_W-1:0] q,
                                                   input logic             inc,
                                                   input logic             carry,
                                                   input logic             clr);
      if (clr || carry) return '0;
      if (inc)          return q + 4'd1;
      return q;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade of the BCD time counter; rolls over at MAX and reports the carry combinationally
// so six instances chain into a single-cycle cascade.
module bcd_digit
   import stopwatch_ctrl_pkg::*;
#(
   parameter logic [3:0] MAX = DIG_MAX_9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   assign carry = inc && (q == MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc) begin
         q <= carry ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/reset state machine, centisecond prescaler and
// mm:ss.cc BCD counter, with a registered six-digit display bus (lap snapshot or live count).
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_ss,
   input  logic             btn_lr,
   output logic             running,
   output logic             lap_hold,
   output logic             wrap,
   output logic [BCD_W-1:0] disp_bcd
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   state_t           state;
   state_t           nxt_state;
   logic [PW-1:0]    presc;
   logic             lr;
   logic             counting;
   logic             tick;
   logic             lap_entry;
   logic             clr;
   logic [5:0]       carry;
   logic [3:0]       cs_u, cs_t, sec_u, sec_t, min_u, min_t;
   logic [BCD_W-1:0] live;
   logic [BCD_W-1:0] live_nxt;
   logic [BCD_W-1:0] snapshot;

   // start/stop has priority: a lap/reset pulse in the same cycle is dropped
   assign lr        = btn_lr && !btn_ss;
   assign counting  = (state == ST_RUN) || (state == ST_LAP);
   assign tick      = counting && (presc == PRE_MAX);
   assign lap_entry = (state == ST_RUN) && lr;
   assign clr       = (state == ST_PAUSE) && lr;

   always_comb begin
      nxt_state = state;
      unique case (state)
         ST_IDLE:  if (btn_ss) nxt_state = ST_RUN;
         ST_RUN:   if (btn_ss) nxt_state = ST_PAUSE; else if (lr) nxt_state = ST_LAP;
         ST_LAP:   if (btn_ss) nxt_state = ST_PAUSE; else if (lr) nxt_state = ST_RUN;
         ST_PAUSE: if (btn_ss) nxt_state = ST_RUN;   else if (lr) nxt_state = ST_IDLE;
         default:  nxt_state = ST_IDLE;
      endcase
   end

   // PAUSE holds the prescaler so the sub-tick phase survives a pause/resume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (state == ST_IDLE || clr) begin
         presc <= '0;
      end else if (counting) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   bcd_digit #(.MAX(DIG_MAX_9)) u_cs_u (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(tick),     .q(cs_u),  .carry(carry[0])
   );
   bcd_digit #(.MAX(DIG_MAX_9)) u_cs_t (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[0]), .q(cs_t),  .carry(carry[1])
   );
   bcd_digit #(.MAX(DIG_MAX_9)) u_sec_u (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[1]), .q(sec_u), .carry(carry[2])
   );
   bcd_digit #(.MAX(DIG_MAX_5)) u_sec_t (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[2]), .q(sec_t), .carry(carry[3])
   );
   bcd_digit #(.MAX(DIG_MAX_9)) u_min_u (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[3]), .q(min_u), .carry(carry[4])
   );
   bcd_digit #(.MAX(DIG_MAX_5)) u_min_t (
      .clk(clk), .rst_n(rst_n), .clr(clr), .inc(carry[4]), .q(min_t), .carry(carry[5])
   );

   always_comb begin
      live     = '0;
      live_nxt = '0;
      live[OFF_CS_U  +: DIG_W]     = cs_u;
      live[OFF_CS_T  +: DIG_W]     = cs_t;
      live[OFF_SEC_U +: DIG_W]     = sec_u;
      live[OFF_SEC_T +: DIG_W]     = sec_t;
      live[OFF_MIN_U +: DIG_W]     = min_u;
      live[OFF_MIN_T +: DIG_W]     = min_t;
      live_nxt[OFF_CS_U  +: DIG_W] = digit_next(cs_u,  tick,     carry[0], clr);
      live_nxt[OFF_CS_T  +: DIG_W] = digit_next(cs_t,  carry[0], carry[1], clr);
      live_nxt[OFF_SEC_U +: DIG_W] = digit_next(sec_u, carry[1], carry[2], clr);
      live_nxt[OFF_SEC_T +: DIG_W] = digit_next(sec_t, carry[2], carry[3], clr);
      live_nxt[OFF_MIN_U +: DIG_W] = digit_next(min_u, carry[3], carry[4], clr);
      live_nxt[OFF_MIN_T +: DIG_W] = digit_next(min_t, carry[4], carry[5], clr);
   end

   // The display register looks at the next state so it changes on the same edge as the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         running  <= 1'b0;
         lap_hold <= 1'b0;
         wrap     <= 1'b0;
         snapshot <= '0;
         disp_bcd <= '0;
      end else begin
         state    <= nxt_state;
         running  <= (nxt_state == ST_RUN) || (nxt_state == ST_LAP);
         lap_hold <= (nxt_state == ST_LAP);
         wrap     <= carry[5];
         if (lap_entry) begin
            snapshot <= live;
         end
         if (nxt_state == ST_LAP) begin
            disp_bcd <= lap_entry ? live : snapshot;
         end else begin
            disp_bcd <= live_nxt;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against a centisecond-count reference model.
module tb_stopwatch_ctrl;

   localparam int DIV     = 10;
   localparam int FULL    = 360000;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_LAP   = 3;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        btn_ss = 1'b0;
   logic        btn_lr = 1'b0;
   logic        running;
   logic        lap_hold;
   logic        wrap;
   logic [23:0] disp_bcd;

   int errors = 0;
   int checks = 0;

   int m_state;
   int m_pre;
   int m_cnt;
   int m_snap;
   bit m_wrap;

   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lr(btn_lr),
      .running(running), .lap_hold(lap_hold), .wrap(wrap), .disp_bcd(disp_bcd)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   function automatic logic [23:0] to_bcd(input int cs);
      int mm, ss, cc;
      mm = cs / 6000;
      ss = (cs / 100) % 60;
      cc = cs % 100;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_pre   = 0;
      m_cnt   = 0;
      m_snap  = 0;
      m_wrap  = 0;
   endtask

   task automatic model_step(input bit ss, input bit lr);
      bit l, counting, tick;
      l        = lr && !ss;
      counting = (m_state == M_RUN) || (m_state == M_LAP);
      tick     = counting && (m_pre == DIV - 1);
      m_wrap   = tick && (m_cnt == FULL - 1);
      if (m_state == M_RUN && l) m_snap = m_cnt;
      if (tick) m_cnt = (m_cnt + 1) % FULL;
      if (counting)              m_pre = tick ? 0 : m_pre + 1;
      else if (m_state == M_IDLE) m_pre = 0;
      case (m_state)
         M_IDLE:  if (ss) m_state = M_RUN;
         M_RUN:   if (ss) m_state = M_PAUSE; else if (l) m_state = M_LAP;
         M_LAP:   if (ss) m_state = M_PAUSE; else if (l) m_state = M_RUN;
         default: begin
            if (ss) m_state = M_RUN;
            else if (l) begin
               m_state = M_IDLE;
               m_cnt   = 0;
               m_pre   = 0;
            end
         end
      endcase
   endtask

   task automatic check_outputs();
      chk("disp", disp_bcd, to_bcd(m_state == M_LAP ? m_snap : m_cnt));
      chk("running", running, (m_state == M_RUN || m_state == M_LAP));
      chk("lap_hold", lap_hold, (m_state == M_LAP));
      chk("wrap", wrap, m_wrap);
   endtask

   task automatic step(input bit ss, input bit lr);
      @(negedge clk);
      btn_ss = ss;
      btn_lr = lr;
      @(posedge clk);
      model_step(ss, lr);
      #1;
      btn_ss = 1'b0;
      btn_lr = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      int wraps;
      int r;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_disp", disp_bcd, 24'h0);
      chk("rst_running", running, 1'b0);
      chk("rst_lap_hold", lap_hold, 1'b0);
      chk("rst_wrap", wrap, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // one second of counting
      step(1'b1, 1'b0);
      idle(1000);
      chk("t1_disp", disp_bcd, 24'h000100);
      chk("t1_running", running, 1'b1);

      // lap freeze and return to live
      do_reset();
      step(1'b1, 1'b0);
      idle(250);
      step(1'b0, 1'b1);
      idle(300);
      chk("t2_lap_hold", lap_hold, 1'b1);
      chk("t2_frozen", disp_bcd, 24'h000025);
      step(1'b0, 1'b1);
      chk("t2_live", disp_bcd, 24'h000055);
      chk("t2_lap_off", lap_hold, 1'b0);

      // pause keeps prescaler phase
      do_reset();
      step(1'b1, 1'b0);
      idle(73);
      step(1'b1, 1'b0);
      chk("t3_paused", disp_bcd, 24'h000007);
      idle(500);
      chk("t3_hold", disp_bcd, 24'h000007);
      step(1'b1, 1'b0);
      k = 0;
      while (disp_bcd !== 24'h000008 && k < 20) begin
         step(1'b0, 1'b0);
         k++;
      end
      chk("t3_resume_lat", k, 6);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      chk("t3_idle_disp", disp_bcd, 24'h0);
      chk("t3_idle_run", running, 1'b0);

      // simultaneous presses: start/stop wins
      do_reset();
      step(1'b1, 1'b0);
      idle(37);
      step(1'b1, 1'b1);
      chk("t4_lap_hold", lap_hold, 1'b0);
      chk("t4_running", running, 1'b0);

      // random press sequences
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4)      step(1'b1, 1'b0);
         else if (r < 8) step(1'b0, 1'b1);
         else if (r < 9) step(1'b1, 1'b1);
         else            step(1'b0, 1'b0);
      end

      // rollover from 59:59.99
      do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      @(negedge clk);
      force dut.u_cs_u.q  = 4'd9;
      force dut.u_cs_t.q  = 4'd9;
      force dut.u_sec_u.q = 4'd9;
      force dut.u_sec_t.q = 4'd5;
      force dut.u_min_u.q = 4'd9;
      force dut.u_min_t.q = 4'd5;
      #1;
      release dut.u_cs_u.q;
      release dut.u_cs_t.q;
      release dut.u_sec_u.q;
      release dut.u_sec_t.q;
      release dut.u_min_u.q;
      release dut.u_min_t.q;
      m_cnt = FULL - 1;
      step(1'b1, 1'b0);
      wraps = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0);
         if (wrap === 1'b1) begin
            wraps++;
            chk("t5_disp_at_wrap", disp_bcd, 24'h0);
            chk("t5_running", running, 1'b1);
         end
      end
      chk("t5_wrap_count", wraps, 1);

      // asynchronous reset between clock edges
      do_reset();
      step(1'b1, 1'b0);
      idle(12340);
      chk("t6_pre_reset", disp_bcd, 24'h001234);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_async_disp", disp_bcd, 24'h0);
      chk("t6_async_running", running, 1'b0);
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b1);
      chk("t6_lr_idle_run", running, 1'b0);
      chk("t6_lr_idle_disp", disp_bcd, 24'h0);
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
